wit_frame_tx: RTL and testbench

//  Serialises WIT-protocol sensor frames (11 bytes: 0x55, type, 4x16-bit LE words, checksum) onto a UART line.

---
 rtl/wit_pkg.sv | 49 ++++
 rtl/uart_tx_byte.sv | 83 ++++++++
 rtl/wit_frame_tx.sv | 189 ++++++++++++++++++
 tb/tb_wit_frame_tx.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wit_pkg.sv
// ----------------------------------------------------------------------------
// wit_pkg
// Shared constants and types for the WIT sensor-frame transmitter.
//   WIT_HEADER      first byte of every frame
//   WIT_FRAME_LEN   bytes per frame including header and checksum
//   WIT_ACCEL/GYRO/ANGLE  common frame type codes (others pass through)
//   tx_state_t      frame FSM state encoding
//   wit_frame_byte  selects frame byte <idx> from the latched frame fields
// ----------------------------------------------------------------------------
package wit_pkg;

    localparam logic [7:0] WIT_HEADER    = 8'h55;
    localparam int         WIT_FRAME_LEN = 11;

    localparam logic [7:0] WIT_ACCEL = 8'h51;
    localparam logic [7:0] WIT_GYRO  = 8'h52;
    localparam logic [7:0] WIT_ANGLE = 8'h53;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_GAP
    } tx_state_t;

    // words is packed {word3, word2, word1, word0}, so payload byte k (2..9)
    // is simply the k-2'th byte of the vector, giving low-byte-first order.
    function automatic logic [7:0] wit_frame_byte(
        input logic [3:0]  idx,
        input logic [7:0]  ftype,
        input logic [63:0] words,
        input logic [7:0]  csum
    );
        logic [7:0] b;
        b = 8'hFF;
        if (idx == 4'd0) begin
            b = WIT_HEADER;
        end else if (idx == 4'd1) begin
            b = ftype;
        end else if (idx <= 4'd9) begin
            b = words[8*(int'(idx)-2) +: 8];
        end else begin
            b = csum;
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// ----------------------------------------------------------------------------
// uart_tx_byte
// Serialises one byte as 8N1: start bit (0), 8 data bits LSB first, stop
// bit (1), each bit held exactly CLKS_PER_BIT clocks (CLKS_PER_BIT >= 2).
//   clk    in   clock
//   rst    in   synchronous active-high reset; line returns high next edge
//   start  in   load data and begin a byte (accepted when idle or in the
//               final cycle of the stop bit)
//   data   in   byte to send
//   txd    out  serial line, idle high
//   done   out  one-cycle pulse in the second-to-last cycle of the stop bit
// ----------------------------------------------------------------------------
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [3:0]       STOP_BIT = 4'd9;

    logic             busy_q, busy_d;
    logic [9:0]       shift_q, shift_d;
    logic [3:0]       bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_cycle;
    logic             accept;

    // done fires one cycle early so the caller can present the next byte in
    // the last stop-bit cycle; the next start bit then follows with no
    // stretched stop bit.
    assign last_cycle = busy_q && (bit_q == STOP_BIT) && (cnt_q == CNT_LAST);
    assign accept     = start && (!busy_q || last_cycle);
    assign done       = busy_q && (bit_q == STOP_BIT) && (cnt_q == CNT_PRE);
    assign txd        = busy_q ? shift_q[0] : 1'b1;

    always_comb begin
        busy_d  = busy_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        if (accept) begin
            busy_d  = 1'b1;
            shift_d = {1'b1, data, 1'b0};
            bit_d   = 4'd0;
            cnt_d   = '0;
        end else if (busy_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (bit_q == STOP_BIT) begin
                    busy_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[9:1]};
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            shift_q <= '1;
            bit_q   <= 4'd0;
            cnt_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/wit_frame_tx.sv
// ----------------------------------------------------------------------------
// wit_frame_tx
// Sends 11-byte WIT sensor frames (0x55, type, 4 LE words, checksum) over a
// built-in 8N1 UART, followed by GAP_BITS idle bit-times.
//   clk, rst          clock, synchronous active-high reset
//   frame_valid/ready handshake; frame latched when both high
//   frame_type        type byte
//   word0..word3      payload words, low byte first on the line
//   txd               UART line, idle high
//   busy              frame being serialised or in its gap
//   frames_sent       completed-frame counter (wraps)
// Optional feature macro: WIT_FRAME_PERIODIC_EN -- re-send the last accepted
// frame after PERIOD_CYCLES idle cycles.
// ----------------------------------------------------------------------------
module wit_frame_tx
    import wit_pkg::*;
#(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int BAUD          = 115_200,
    parameter int GAP_BITS      = 2,
    parameter int PERIOD_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [7:0]  frame_type,
    input  logic [15:0] word0,
    input  logic [15:0] word1,
    input  logic [15:0] word2,
    input  logic [15:0] word3,
    output logic        txd,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int GAP_TOTAL    = GAP_BITS * CLKS_PER_BIT;
    // The GAP state starts during the final stop-bit cycle, and the next
    // frame spends IDLE/LOAD/SEND before its start bit; those overlap the
    // idle line time, so GAP itself is two cycles shorter. It never drops
    // below one cycle, so frames are always separated by an IDLE cycle.
    localparam int GAP_CYCLES   = (GAP_TOTAL > 2) ? (GAP_TOTAL - 2) : 1;
    localparam int GAP_W        = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX = 4'(WIT_FRAME_LEN - 1);

    tx_state_t         state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        type_q, type_d;
    logic [63:0]       words_q, words_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [15:0]       sent_q, sent_d;
    logic              uart_start;
    logic              uart_done;
    logic [7:0]        cur_byte;

`ifdef WIT_FRAME_PERIODIC_EN
    localparam int PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
    logic              have_q, have_d;
    logic [PER_W-1:0]  per_q, per_d;
`else
    logic              unused_period_cfg;
    assign unused_period_cfg = (PERIOD_CYCLES > 0);
`endif

    assign cur_byte    = wit_frame_byte(idx_q, type_q, words_q, csum_q);
    assign busy        = (state_q != ST_IDLE);
    assign frame_ready = (state_q == ST_IDLE) && !rst;
    assign frames_sent = sent_q;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk  (clk),
        .rst  (rst),
        .start(uart_start),
        .data (cur_byte),
        .txd  (txd),
        .done (uart_done)
    );

    // Frame sequencer: latch on handshake, hand bytes to the UART one at a
    // time, accumulate the checksum as each byte goes out, then hold the
    // gap before allowing the next frame.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        type_d     = type_q;
        words_d    = words_q;
        gap_d      = gap_q;
        sent_d     = sent_q;
        uart_start = 1'b0;
`ifdef WIT_FRAME_PERIODIC_EN
        have_d     = have_q;
        per_d      = per_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (frame_valid) begin
                    type_d  = frame_type;
                    words_d = {word3, word2, word1, word0};
                    state_d = ST_LOAD;
`ifdef WIT_FRAME_PERIODIC_EN
                    have_d  = 1'b1;
                    per_d   = '0;
`endif
                end
`ifdef WIT_FRAME_PERIODIC_EN
                // Resend reuses the latched fields untouched.
                else if (have_q) begin
                    if (per_q == PER_LAST) begin
                        per_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        per_d = per_q + 1'b1;
                    end
                end
`endif
            end
            ST_LOAD: begin
                idx_d   = 4'd0;
                csum_d  = 8'h00;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                uart_start = 1'b1;
                if (idx_q != LAST_IDX) begin
                    csum_d = csum_q + cur_byte;
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (uart_done) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_SEND;
                    end else begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    sent_d  = sent_q + 16'd1;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            csum_q  <= 8'h00;
            type_q  <= 8'h00;
            words_q <= '0;
            gap_q   <= '0;
            sent_q  <= 16'd0;
`ifdef WIT_FRAME_PERIODIC_EN
            have_q  <= 1'b0;
            per_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            type_q  <= type_d;
            words_q <= words_d;
            gap_q   <= gap_d;
            sent_q  <= sent_d;
`ifdef WIT_FRAME_PERIODIC_EN
            have_q  <= have_d;
            per_q   <= per_d;
`endif
        end
    end

endmodule

// File: tb/tb_wit_frame_tx.sv
// ----------------------------------------------------------------------------
// tb_wit_frame_tx
// Directed bench for wit_frame_tx at 10 clocks per bit, GAP_BITS=2.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// ----------------------------------------------------------------------------
module tb_wit_frame_tx;

    localparam int CLK_FREQ      = 1_000_000;
    localparam int BAUD          = 100_000;
    localparam int GAP_BITS      = 2;
    localparam int PERIOD_CYCLES = 5000;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_valid;
    logic        frame_ready;
    logic [7:0]  frame_type;
    logic [15:0] word0, word1, word2, word3;
    logic        txd;
    logic        busy;
    logic [15:0] frames_sent;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_bytes [11];
    int         rx_width_err;
    bit         rx_timeout;
    int         wait_cycles;

    logic [7:0] exp_t1 [11] = '{8'h55, 8'h52, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h34, 8'h12, 8'hB8, 8'h0B, 8'hB0};
    logic [7:0] exp_t3 [11] = '{8'h55, 8'h53, 8'h01, 8'h00, 8'h02, 8'h00,
                                8'h03, 8'h00, 8'h04, 8'h00, 8'hB2};

    always #5 clk = ~clk;

    wit_frame_tx #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .GAP_BITS     (GAP_BITS),
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_type (frame_type),
        .word0      (word0),
        .word1      (word1),
        .word2      (word2),
        .word3      (word3),
        .txd        (txd),
        .busy       (busy),
        .frames_sent(frames_sent)
    );

    // One-cycle handshake pulse; returns on the sample after the accept edge.
    task automatic start_frame(input logic [7:0] t, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] c,
                               input logic [15:0] d);
        @(negedge clk);
        frame_type  = t;
        word0 = a; word1 = b; word2 = c; word3 = d;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    // Waits (bounded) for a start bit, then reads 11 bytes sampling every
    // cycle; any bit whose 10 samples disagree, or a bad start/stop bit,
    // counts as a width error. Ends on the first sample after the last stop.
    task automatic rx_frame(input int max_wait);
        int         n;
        logic [9:0] bits;
        logic       first;
        rx_timeout   = 1'b0;
        rx_width_err = 0;
        bits         = '0;
        for (int i = 0; i < 11; i++) rx_bytes[i] = 8'h00;
        n = 0;
        while (txd !== 1'b0 && n < max_wait) begin
            @(negedge clk);
            n++;
        end
        if (txd !== 1'b0) begin
            rx_timeout = 1'b1;
        end else begin
            for (int by = 0; by < 11; by++) begin
                for (int bt = 0; bt < 10; bt++) begin
                    first = txd;
                    for (int s = 1; s < 10; s++) begin
                        @(negedge clk);
                        if (txd !== first) rx_width_err++;
                    end
                    bits[bt] = first;
                    @(negedge clk);
                end
                rx_bytes[by] = bits[8:1];
                if (bits[0] !== 1'b0 || bits[9] !== 1'b1) rx_width_err++;
            end
        end
    endtask

    task automatic wait_ready(input int max_wait);
        wait_cycles = 0;
        while (frame_ready !== 1'b1 && wait_cycles < max_wait) begin
            @(negedge clk);
            wait_cycles++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        frame_valid = 1'b0;
        frame_type = 8'h00;
        word0 = 16'h0; word1 = 16'h0; word2 = 16'h0; word3 = 16'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (frame_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready_in_rst: got %b expected 0", frame_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (frame_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b expected 1", frame_ready);
        end
        checks++;
        if (txd !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_txd: got %b expected 1", txd);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (frames_sent !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_frames_sent: got %0d expected 0", frames_sent);
        end
    endtask

    task automatic test_single_frame;
        start_frame(8'h52, 16'h0000, 16'h0000, 16'h1234, 16'h0BB8);
        // After accept edge N: LOAD, then SEND, start bit after edge N+2.
        checks++;
        if (busy !== 1'b1 || frame_ready !== 1'b0 || txd !== 1'b1) begin
            failures++;
            $display("[TB] FAIL t1_after_accept: busy=%b ready=%b txd=%b expected 1 0 1",
                     busy, frame_ready, txd);
        end
        @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin
            failures++;
            $display("[TB] FAIL t1_latency_n1: got txd=%b expected 1", txd);
        end
        @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL t1_latency_n2: got txd=%b expected 0", txd);
        end
        rx_frame(5);
        checks++;
        if (rx_timeout || rx_width_err != 0) begin
            failures++;
            $display("[TB] FAIL t1_framing: timeout=%b width_errors=%0d expected 0 0",
                     rx_timeout, rx_width_err);
        end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (rx_bytes[i] !== exp_t1[i]) begin
                failures++;
                $display("[TB] FAIL t1_byte%0d: got %02h expected %02h", i, rx_bytes[i], exp_t1[i]);
            end
        end
        // Frame is 1120 cycles handshake-to-handshake; stop bit ends 1102
        // after accept, so ready returns 17 samples later.
        wait_ready(200);
        checks++;
        if (wait_cycles != 17) begin
            failures++;
            $display("[TB] FAIL t1_gap_to_ready: got %0d cycles expected 17", wait_cycles);
        end
        checks++;
        if (frames_sent !== 16'd1) begin
            failures++;
            $display("[TB] FAIL t1_frames_sent: got %0d expected 1", frames_sent);
        end
    endtask

    task automatic test_checksum_wrap;
        start_frame(8'hFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        rx_frame(50);
        checks++;
        if (rx_timeout || rx_width_err != 0) begin
            failures++;
            $display("[TB] FAIL t2_bit_width: timeout=%b width_errors=%0d expected 0 0",
                     rx_timeout, rx_width_err);
        end
        checks++;
        if (rx_bytes[1] !== 8'hFF || rx_bytes[9] !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL t2_payload: got %02h %02h expected ff ff", rx_bytes[1], rx_bytes[9]);
        end
        checks++;
        if (rx_bytes[10] !== 8'h4C) begin
            failures++;
            $display("[TB] FAIL t2_checksum: got %02h expected 4c", rx_bytes[10]);
        end
        wait_ready(200);
        checks++;
        if (frames_sent !== 16'd2) begin
            failures++;
            $display("[TB] FAIL t2_frames_sent: got %0d expected 2", frames_sent);
        end
    endtask

    task automatic test_back_to_back;
        int idle;
        int bad;
        @(negedge clk);
        frame_type = 8'h53;
        word0 = 16'h0001; word1 = 16'h0002; word2 = 16'h0003; word3 = 16'h0004;
        frame_valid = 1'b1;
        for (int f = 0; f < 3; f++) begin
            rx_frame(50);
            bad = 0;
            for (int i = 0; i < 11; i++) if (rx_bytes[i] !== exp_t3[i]) bad++;
            checks++;
            if (rx_timeout || rx_width_err != 0 || bad != 0) begin
                failures++;
                $display("[TB] FAIL t3_frame%0d: timeout=%b width_errors=%0d bad_bytes=%0d expected 0 0 0",
                         f, rx_timeout, rx_width_err, bad);
            end
            if (f < 2) begin
                idle = 0;
                while (txd === 1'b1 && idle < 100) begin
                    idle++;
                    @(negedge clk);
                end
                checks++;
                if (idle != 20) begin
                    failures++;
                    $display("[TB] FAIL t3_gap%0d: got %0d idle cycles expected 20", f, idle);
                end
            end else begin
                frame_valid = 1'b0;
            end
        end
        wait_ready(200);
        checks++;
        if (frames_sent !== 16'd5) begin
            failures++;
            $display("[TB] FAIL t3_frames_sent: got %0d expected 5", frames_sent);
        end
        idle = 0;
        repeat (300) begin
            @(negedge clk);
            if (txd !== 1'b1) idle++;
        end
        checks++;
        if (idle != 0) begin
            failures++;
            $display("[TB] FAIL t3_no_extra_frame: got %0d low samples expected 0", idle);
        end
    endtask

    task automatic test_reset_mid_frame;
        int n;
        int low;
        start_frame(8'h52, 16'h0000, 16'h0000, 16'h1234, 16'h0BB8);
        n = 0;
        while (txd !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        // Bytes 0..4 take 500 cycles; 535 lands inside byte 5.
        repeat (535) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL t4_abort: txd=%b busy=%b expected 1 0", txd, busy);
        end
        // Reset clears the counter; the aborted frame is never counted.
        checks++;
        if (frames_sent !== 16'd0) begin
            failures++;
            $display("[TB] FAIL t4_frames_sent_rst: got %0d expected 0", frames_sent);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (frame_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL t4_ready: got %b expected 1", frame_ready);
        end
        low = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1) low++;
        end
        checks++;
        if (low != 0) begin
            failures++;
            $display("[TB] FAIL t4_line_idle: got %0d low samples expected 0", low);
        end
        start_frame(8'h52, 16'h0000, 16'h0000, 16'h1234, 16'h0BB8);
        rx_frame(10);
        n = 0;
        for (int i = 0; i < 11; i++) if (rx_bytes[i] !== exp_t1[i]) n++;
        checks++;
        if (rx_timeout || rx_width_err != 0 || n != 0) begin
            failures++;
            $display("[TB] FAIL t4_clean_frame: timeout=%b width_errors=%0d bad_bytes=%0d expected 0 0 0",
                     rx_timeout, rx_width_err, n);
        end
        wait_ready(200);
        checks++;
        if (frames_sent !== 16'd1) begin
            failures++;
            $display("[TB] FAIL t4_frames_sent: got %0d expected 1", frames_sent);
        end
    endtask

    // Receiver-side view: a parser keyed on header/type extracts word2 as
    // angular velocity Z and validates the trailing checksum.
    task automatic test_loopback;
        logic [7:0]  sum;
        logic [15:0] angular_v;
        start_frame(8'h52, 16'h0000, 16'h0000, 16'h1234, 16'h0BB8);
        rx_frame(10);
        sum = 8'h00;
        for (int i = 0; i < 10; i++) sum = sum + rx_bytes[i];
        angular_v = {rx_bytes[7], rx_bytes[6]};
        checks++;
        if (rx_timeout || rx_bytes[0] !== 8'h55 || rx_bytes[1] !== 8'h52 || rx_bytes[10] !== sum) begin
            failures++;
            $display("[TB] FAIL t5_parse: hdr=%02h type=%02h csum=%02h expected 55 52 %02h",
                     rx_bytes[0], rx_bytes[1], rx_bytes[10], sum);
        end
        checks++;
        if (angular_v !== 16'h1234) begin
            failures++;
            $display("[TB] FAIL t5_angular_v: got %04h expected 1234", angular_v);
        end
        wait_ready(200);
        checks++;
        if (frames_sent !== 16'd2) begin
            failures++;
            $display("[TB] FAIL t5_frames_sent: got %0d expected 2", frames_sent);
        end
    endtask

`ifdef WIT_FRAME_PERIODIC_EN
    task automatic test_periodic;
        int low;
        int bad;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        low = 0;
        repeat (6000) begin
            @(negedge clk);
            if (txd !== 1'b1) low++;
        end
        checks++;
        if (low != 0) begin
            failures++;
            $display("[TB] FAIL t6_quiet_before_handshake: got %0d low samples expected 0", low);
        end
        start_frame(8'h52, 16'h0000, 16'h0000, 16'h1234, 16'h0BB8);
        rx_frame(10);
        wait_ready(200);
        frame_type = 8'h00;
        word0 = 16'h0; word1 = 16'h0; word2 = 16'h0; word3 = 16'h0;
        rx_frame(8000);
        bad = 0;
        for (int i = 0; i < 11; i++) if (rx_bytes[i] !== exp_t1[i]) bad++;
        checks++;
        if (rx_timeout || rx_width_err != 0 || bad != 0) begin
            failures++;
            $display("[TB] FAIL t6_resend: timeout=%b width_errors=%0d bad_bytes=%0d expected 0 0 0",
                     rx_timeout, rx_width_err, bad);
        end
        wait_ready(200);
        checks++;
        if (frames_sent !== 16'd2) begin
            failures++;
            $display("[TB] FAIL t6_frames_sent: got %0d expected 2", frames_sent);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_checksum_wrap();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
`ifdef WIT_FRAME_PERIODIC_EN
        test_periodic();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
